// File: rtl/tl45_scoreboard_if.sv
// Scoreboard bus bundle: issue request from decode, forward-bus tags, writeback retire
// tags, and the busy/stall/error status returned to register-read.
// Signal names match the scoreboard's port list so the two read side by side.
interface tl45_scoreboard_if #(
    parameter int NREGS = 15
);
    logic             i_flush;
    logic             i_issue_valid;
    logic [3:0]       i_issue_dr;
    logic [3:0]       i_issue_sr1;
    logic [3:0]       i_issue_sr2;
    logic             i_issue_ri;
    logic             i_issue_nobusy;
    logic [3:0]       i_of1_reg;
    logic [3:0]       i_of2_reg;
    logic [3:0]       i_wb1_reg;
    logic [3:0]       i_wb2_reg;
    logic [NREGS-1:0] o_busylist;
    logic             o_stall;
    logic             o_underflow;

    // Pipeline side: drives issue, forward and retire; observes status.
    modport master (
        output i_flush, i_issue_valid, i_issue_dr, i_issue_sr1, i_issue_sr2,
               i_issue_ri, i_issue_nobusy, i_of1_reg, i_of2_reg, i_wb1_reg, i_wb2_reg,
        input  o_busylist, o_stall, o_underflow
    );

    // Scoreboard side.
    modport slave (
        input  i_flush, i_issue_valid, i_issue_dr, i_issue_sr1, i_issue_sr2,
               i_issue_ri, i_issue_nobusy, i_of1_reg, i_of2_reg, i_wb1_reg, i_wb2_reg,
        output o_busylist, o_stall, o_underflow
    );
endinterface

// File: rtl/tl45_scoreboard.sv
// TL45 register-hazard scoreboard. Each tracked register r1..rNREGS has a small
// counter of DPRF writes still in flight. An issuing instruction stalls if any
// operand is pending and cannot be taken from a forward bus, or if its destination
// counter is already full. Retires from the two writeback ports decrement counters.
// Optional macro TL45_SCOREBOARD_PERF_EN adds a saturating stall-cycle counter port.
module tl45_scoreboard #(
    parameter int NREGS = 15,
    parameter int CNT_W = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    tl45_scoreboard_if.slave    sb
`ifdef TL45_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]         o_stall_cycles
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [1:NREGS];
    logic [CNT_W-1:0] cnt_d [1:NREGS];
    logic             underflow_q, underflow_d;

    logic [CNT_W-1:0] cnt_sr1, cnt_sr2, cnt_dr;
    logic             stall;
    logic             issue_fire;
    logic [NREGS-1:0] busy;

    // A source can be forwarded only when exactly one write is pending; with two or
    // more in flight the bus may be carrying the older value.
    function automatic logic hazard(input logic [3:0]       s,
                                    input logic [CNT_W-1:0] c,
                                    input logic [3:0]       of1,
                                    input logic [3:0]       of2);
        logic fwd_ok;
        fwd_ok = ((s == of1) || (s == of2)) && (s != 4'd0) && (c == CNT_W'(1));
        return (s != 4'd0) && (c != '0) && !fwd_ok;
    endfunction

    // Look up the counters of the issuing instruction's operands and destination.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned and a latch is never inferred.
        cnt_sr1 = '0;
        cnt_sr2 = '0;
        cnt_dr  = '0;
        for (int r = 1; r <= NREGS; r++) begin
            if (sb.i_issue_sr1 == 4'(r)) cnt_sr1 = cnt_q[r];
            if (sb.i_issue_sr2 == 4'(r)) cnt_sr2 = cnt_q[r];
            if (sb.i_issue_dr  == 4'(r)) cnt_dr  = cnt_q[r];
        end
    end

    // Stall decision and the resulting issue acceptance.
    always_comb begin
        stall = sb.i_issue_valid &&
                (hazard(sb.i_issue_sr1, cnt_sr1, sb.i_of1_reg, sb.i_of2_reg) ||
                 (!sb.i_issue_ri && hazard(sb.i_issue_sr2, cnt_sr2, sb.i_of1_reg, sb.i_of2_reg)) ||
                 ((sb.i_issue_dr != 4'd0) && !sb.i_issue_nobusy && (cnt_dr == CNT_MAX)));
        issue_fire = sb.i_issue_valid && !stall && !sb.i_flush && !sb.i_issue_nobusy &&
                     (sb.i_issue_dr != 4'd0);
    end

    // Next counter values: +1 for an accepted issue, -1 per retire port naming the
    // register, clamped at zero with the sticky underflow flag raised on clamp.
    always_comb begin
        int sum;
        int dec;
        underflow_d = underflow_q;
        sum = 0;
        dec = 0;
        for (int r = 1; r <= NREGS; r++) begin
            sum = int'(cnt_q[r]) + ((issue_fire && (sb.i_issue_dr == 4'(r))) ? 1 : 0);
            dec = ((sb.i_wb1_reg == 4'(r)) ? 1 : 0) + ((sb.i_wb2_reg == 4'(r)) ? 1 : 0);
            if (dec > sum) begin
                cnt_d[r]    = '0;
                underflow_d = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum - dec);
            end
        end
    end

    // Busy list straight from the counter registers.
    always_comb begin
        busy = '0;
        for (int r = 1; r <= NREGS; r++) begin
            busy[r-1] = (cnt_q[r] != '0);
        end
    end

    assign sb.o_busylist  = busy;
    assign sb.o_stall     = stall;
    assign sb.o_underflow = underflow_q;

    // Counter and error-flag registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge values regardless of block ordering.
        if (i_reset) begin
            // NOTE: the counter array is small and must read zero after reset, so it is
            // built from resettable flops rather than a RAM.
            for (int r = 1; r <= NREGS; r++) cnt_q[r] <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int r = 1; r <= NREGS; r++) cnt_q[r] <= cnt_d[r];
            underflow_q <= underflow_d;
        end
    end

`ifdef TL45_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles in which issue was held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall-cycle counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) stall_cycles_q <= '0;
        else         stall_cycles_q <= stall_cycles_d;
    end

    assign o_stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_tl45_scoreboard.sv
// Self-checking bench for tl45_scoreboard: directed scenarios followed by random
// traffic, all compared against an integer-count reference model of the rules.
module tb_tl45_scoreboard;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tl45_scoreboard_if sb ();
`ifdef TL45_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    tl45_scoreboard dut (
        .i_clk   (clk),
        .i_reset (rst),
        .sb      (sb)
`ifdef TL45_SCOREBOARD_PERF_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain per-register in-flight counts.
    int mcnt [16];
    bit muf;
    int mstall_cycles;
    bit exp_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hazard(input int s, input int of1, input int of2);
        bit fwd;
        fwd = (s == of1 || s == of2) && s != 0 && mcnt[s] == 1;
        return s != 0 && mcnt[s] != 0 && !fwd;
    endfunction

    function automatic logic [14:0] m_busy();
        logic [14:0] b;
        b = '0;
        for (int r = 1; r <= 15; r++) b[r-1] = (mcnt[r] != 0);
        return b;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 16; r++) mcnt[r] = 0;
        muf = 1'b0;
        mstall_cycles = 0;
    endtask

    task automatic idle();
        rst               = 1'b0;
        sb.i_flush        = 1'b0;
        sb.i_issue_valid  = 1'b0;
        sb.i_issue_dr     = 4'd0;
        sb.i_issue_sr1    = 4'd0;
        sb.i_issue_sr2    = 4'd0;
        sb.i_issue_ri     = 1'b0;
        sb.i_issue_nobusy = 1'b0;
        sb.i_of1_reg      = 4'd0;
        sb.i_of2_reg      = 4'd0;
        sb.i_wb1_reg      = 4'd0;
        sb.i_wb2_reg      = 4'd0;
    endtask

    task automatic issue(input int dr, input int sr1, input int sr2);
        sb.i_issue_valid = 1'b1;
        sb.i_issue_dr    = 4'(dr);
        sb.i_issue_sr1   = 4'(sr1);
        sb.i_issue_sr2   = 4'(sr2);
    endtask

    // Let inputs settle, then compare combinational outputs against the model.
    task automatic settle(input string tag);
        int of1, of2;
        #1;
        of1 = int'(sb.i_of1_reg);
        of2 = int'(sb.i_of2_reg);
        exp_stall = sb.i_issue_valid &&
                    (m_hazard(int'(sb.i_issue_sr1), of1, of2) ||
                     (!sb.i_issue_ri && m_hazard(int'(sb.i_issue_sr2), of1, of2)) ||
                     (sb.i_issue_dr != 0 && !sb.i_issue_nobusy && mcnt[sb.i_issue_dr] == MAXC));
        check({tag, " stall"},     32'(sb.o_stall),     32'(exp_stall));
        check({tag, " busylist"},  32'(sb.o_busylist),  32'(m_busy()));
        check({tag, " underflow"}, 32'(sb.o_underflow), 32'(muf));
    endtask

    // Advance the model with the current inputs, then step one clock.
    task automatic clock();
        int  nxt [16];
        bit  nuf;
        bit  fire;
        int  n;
        int  nsc;
        fire = sb.i_issue_valid && !exp_stall && !sb.i_flush && !sb.i_issue_nobusy &&
               sb.i_issue_dr != 0;
        nuf = muf;
        nsc = mstall_cycles + (exp_stall ? 1 : 0);
        nxt[0] = 0;
        for (int r = 1; r < 16; r++) begin
            n = mcnt[r] + ((fire && sb.i_issue_dr == r) ? 1 : 0)
                        - ((sb.i_wb1_reg == r) ? 1 : 0) - ((sb.i_wb2_reg == r) ? 1 : 0);
            if (n < 0) begin
                n   = 0;
                nuf = 1'b1;
            end
            nxt[r] = n;
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int r = 0; r < 16; r++) mcnt[r] = nxt[r];
            muf = nuf;
            mstall_cycles = nsc;
        end
        @(negedge clk);
    endtask

    task automatic tick(input string tag);
        settle(tag);
        clock();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Reset state.
        settle("reset");
        check("reset busylist", 32'(sb.o_busylist), 32'h0);
        check("reset underflow", 32'(sb.o_underflow), 32'h0);
        check("reset stall", 32'(sb.o_stall), 32'h0);
`ifdef TL45_SCOREBOARD_PERF_EN
        check("reset stall_cycles", stall_cycles, 32'h0);
`endif
        clock();

        // 1) issue dr=3 -> busy bit 2 next cycle.
        idle(); issue(3, 0, 0); tick("t1 issue");
        idle(); issue(0, 0, 0); settle("t1 after");
        check("t1 busylist", 32'(sb.o_busylist), 32'h0004);
        check("t1 stall", 32'(sb.o_stall), 32'h0);
        clock();

        // 2) cnt[3]=1: forwardable via of1, stalls without forward.
        idle(); issue(0, 3, 0); sb.i_of1_reg = 4'd3; settle("t2 fwd");
        check("t2 fwd stall", 32'(sb.o_stall), 32'h0);
        clock();
        idle(); issue(0, 3, 0); settle("t2 nofwd");
        check("t2 nofwd stall", 32'(sb.o_stall), 32'h1);
        clock();

        // 3) two writes on r5: forwarding refused until one retires.
        idle(); issue(5, 0, 0); tick("t3 issue a");
        idle(); issue(5, 0, 0); tick("t3 issue b");
        idle(); issue(0, 5, 0); sb.i_of2_reg = 4'd5; settle("t3 cnt2");
        check("t3 cnt2 stall", 32'(sb.o_stall), 32'h1);
        clock();
        idle(); sb.i_wb1_reg = 4'd5; tick("t3 retire");
        idle(); issue(0, 5, 0); sb.i_of2_reg = 4'd5; settle("t3 cnt1");
        check("t3 cnt1 stall", 32'(sb.o_stall), 32'h0);
        clock();

        // 4) same-cycle issue and retire on r7 nets out.
        idle(); issue(7, 0, 0); tick("t4 issue");
        idle(); issue(7, 0, 0); sb.i_wb1_reg = 4'd7; settle("t4 both");
        check("t4 both busy6", 32'(sb.o_busylist[6]), 32'h1);
        clock();
        idle(); settle("t4 after");
        check("t4 after busy6", 32'(sb.o_busylist[6]), 32'h1);
        clock();
        idle(); sb.i_wb1_reg = 4'd7; tick("t4 retire");
        idle(); settle("t4 drained");
        check("t4 drained busy6", 32'(sb.o_busylist[6]), 32'h0);
        clock();

        // 5) retire on idle r9 -> sticky underflow, cleared by reset.
        idle(); sb.i_wb1_reg = 4'd9; tick("t5 retire");
        idle(); settle("t5 flag");
        check("t5 underflow", 32'(sb.o_underflow), 32'h1);
        check("t5 busy8", 32'(sb.o_busylist[8]), 32'h0);
        clock();
        idle(); tick("t5 hold a");
        idle(); settle("t5 hold b");
        check("t5 underflow held", 32'(sb.o_underflow), 32'h1);
        clock();
        idle(); sb.i_wb1_reg = 4'd3; sb.i_wb2_reg = 4'd5; rst = 1'b1; tick("t5 reset");
        idle(); settle("t5 cleared");
        check("t5 underflow cleared", 32'(sb.o_underflow), 32'h0);
        check("t5 busylist cleared", 32'(sb.o_busylist), 32'h0);
        clock();

        // 6) saturate r2, stall on full counter, flush blocks issue.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(2, 0, 0); tick("t6 fill");
        end
        for (int i = 0; i < 4; i++) begin
            idle(); issue(2, 0, 0); settle("t6 full");
            check("t6 full stall", 32'(sb.o_stall), 32'h1);
            clock();
        end
        idle(); issue(4, 0, 0); sb.i_flush = 1'b1; settle("t6 flush");
        check("t6 flush stall", 32'(sb.o_stall), 32'h0);
        clock();
        idle(); settle("t6 after flush");
        check("t6 busy3", 32'(sb.o_busylist[3]), 32'h0);
        check("t6 busy1", 32'(sb.o_busylist[1]), 32'h1);
`ifdef TL45_SCOREBOARD_PERF_EN
        check("t6 stall_cycles", stall_cycles, 32'd4);
`endif
        clock();
        idle(); sb.i_wb1_reg = 4'd2; sb.i_wb2_reg = 4'd2; tick("t6 dual retire");
        idle(); issue(0, 2, 0); sb.i_of1_reg = 4'd2; settle("t6 cnt1 fwd");
        check("t6 cnt1 fwd stall", 32'(sb.o_stall), 32'h0);
        clock();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            idle();
            rst               = ($urandom_range(0, 79) == 0);
            sb.i_issue_valid  = ($urandom_range(0, 3) != 0);
            sb.i_issue_dr     = 4'($urandom_range(0, 15));
            sb.i_issue_sr1    = 4'($urandom_range(0, 15));
            sb.i_issue_sr2    = 4'($urandom_range(0, 15));
            sb.i_issue_ri     = 1'($urandom_range(0, 1));
            sb.i_issue_nobusy = ($urandom_range(0, 5) == 0);
            sb.i_flush        = ($urandom_range(0, 7) == 0);
            sb.i_of1_reg      = $urandom_range(0, 1) ? sb.i_issue_sr1 : 4'($urandom_range(0, 15));
            sb.i_of2_reg      = $urandom_range(0, 1) ? sb.i_issue_sr2 : 4'($urandom_range(0, 15));
            sb.i_wb1_reg      = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
            sb.i_wb2_reg      = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            tick("rnd");
`ifdef TL45_SCOREBOARD_PERF_EN
            check("rnd stall_cycles", stall_cycles, 32'(mstall_cycles));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
